// File: rtl/sig_dump_pkg.sv
// Shared types, default signature addresses and FSM states for the signature dump emitter.
package sig_dump_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;

  localparam addr_t DEF_ADDR_STOP     = 64'h0;
  localparam addr_t DEF_ADDR_TRAP     = 64'h8;
  localparam addr_t DEF_ADDR_INT_DUMP = 64'h10;
  localparam addr_t DEF_ADDR_FP_DUMP  = 64'h18;

  localparam strb_t STRB_FULL = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    INT_RD,
    INT_CAP,
    INT_WR,
    FP_RD,
    FP_CAP,
    FP_WR,
    STOP_WR,
    TRAP_WR,
    DONE
  } state_e;

endpackage

// File: rtl/sig_dump_emitter.sv
// Signature-write initiator: dumps x1..xN then f0..fM to fixed addresses, then writes the stop
// signature; a trap request from IDLE emits a single trap-signature write instead.
module sig_dump_emitter
  import sig_dump_pkg::*;
#(
  parameter int    NR_INT_REGS   = 31,
  parameter int    NR_FP_REGS    = 32,
  parameter addr_t ADDR_STOP     = DEF_ADDR_STOP,
  parameter addr_t ADDR_TRAP     = DEF_ADDR_TRAP,
  parameter addr_t ADDR_INT_DUMP = DEF_ADDR_INT_DUMP,
  parameter addr_t ADDR_FP_DUMP  = DEF_ADDR_FP_DUMP
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        trap_i,
  input  data_t       trap_cause_i,
  output logic [4:0]  int_raddr_o,
  input  data_t       int_rdata_i,
  output logic [4:0]  fp_raddr_o,
  input  data_t       fp_rdata_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output addr_t       mem_addr_o,
  output data_t       mem_wdata_o,
  output strb_t       mem_strb_o,
  output logic        mem_we_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [5:0] INT_LAST = 6'(NR_INT_REGS - 1);
  localparam logic [5:0] FP_LAST  = (NR_FP_REGS > 0) ? 6'(NR_FP_REGS - 1) : 6'd0;

  state_e     state_reg, state_next;
  logic [5:0] idx_reg, idx_next;
  logic [4:0] int_raddr_reg, int_raddr_next;
  logic [4:0] fp_raddr_reg, fp_raddr_next;
  logic       req_reg, req_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  addr_t      addr_reg, addr_next;
  data_t      wdata_reg, wdata_next;

  logic       fp_phase;
  logic       handshake;
  logic [5:0] last_idx;

  // INT and FP dumps share one read/capture/write path; the phase bit picks source and address.
  assign fp_phase  = (state_reg == FP_RD) || (state_reg == FP_CAP) || (state_reg == FP_WR);
  assign handshake = req_reg & mem_gnt_i;
  assign last_idx  = fp_phase ? FP_LAST : INT_LAST;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      int_raddr_reg <= '0;
      fp_raddr_reg  <= '0;
      req_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      int_raddr_reg <= int_raddr_next;
      fp_raddr_reg  <= fp_raddr_next;
      req_reg       <= req_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    int_raddr_next = int_raddr_reg;
    fp_raddr_next  = fp_raddr_reg;
    req_next       = req_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;

    case (state_reg)
      IDLE: begin
        if (trap_i) begin
          state_next = TRAP_WR;
          addr_next  = ADDR_TRAP;
          wdata_next = trap_cause_i;
          busy_next  = 1'b1;
        end else if (start_i) begin
          state_next     = INT_RD;
          idx_next       = '0;
          int_raddr_next = 5'd1;
          busy_next      = 1'b1;
        end
      end

      // Read address was already presented on entry; the RF answers one cycle later.
      INT_RD, FP_RD: begin
        state_next = fp_phase ? FP_CAP : INT_CAP;
      end

      INT_CAP, FP_CAP: begin
        wdata_next = fp_phase ? fp_rdata_i : int_rdata_i;
        addr_next  = fp_phase ? ADDR_FP_DUMP : ADDR_INT_DUMP;
        req_next   = 1'b1;
        state_next = fp_phase ? FP_WR : INT_WR;
      end

      INT_WR, FP_WR: begin
        if (handshake) begin
          req_next = 1'b0;
          if (idx_reg >= last_idx) begin
            idx_next = '0;
            if (!fp_phase && (NR_FP_REGS > 0)) begin
              state_next    = FP_RD;
              fp_raddr_next = 5'd0;
            end else begin
              state_next = STOP_WR;
            end
          end else begin
            idx_next = idx_reg + 6'd1;
            if (fp_phase) begin
              state_next    = FP_RD;
              fp_raddr_next = 5'(idx_reg + 6'd1);
            end else begin
              state_next     = INT_RD;
              int_raddr_next = 5'(idx_reg + 6'd2);
            end
          end
        end
      end

      // Request rises the cycle after entry so the previous write's address never lingers with req.
      STOP_WR: begin
        addr_next  = ADDR_STOP;
        wdata_next = '0;
        if (handshake) begin
          req_next   = 1'b0;
          state_next = DONE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end else begin
          req_next = 1'b1;
        end
      end

      TRAP_WR: begin
        if (handshake) begin
          req_next   = 1'b0;
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          req_next = 1'b1;
        end
      end

      DONE: begin
        req_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign int_raddr_o = int_raddr_reg;
  assign fp_raddr_o  = fp_raddr_reg;
  assign mem_req_o   = req_reg;
  assign mem_we_o    = req_reg;
  assign mem_strb_o  = req_reg ? STRB_FULL : '0;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;

endmodule

// File: tb/tb_sig_dump_emitter.sv
// Scoreboard bench for sig_dump_emitter: default build plus a build with the FP phase disabled.
module tb_sig_dump_emitter;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] d;
  } wr_t;

  logic        clk;
  logic        rst, start, trap;
  logic [63:0] trap_cause;
  logic [4:0]  int_raddr, fp_raddr;
  logic [63:0] int_rdata, fp_rdata;
  logic        req, we, busy, done;
  logic        gnt = 1'b1;
  logic [63:0] addr, wdata;
  logic [7:0]  strb;

  logic        rst0, start0;
  logic [4:0]  int_raddr0, fp_raddr0;
  logic [63:0] int_rdata0, fp_rdata0;
  logic        req0, we0, busy0, done0;
  logic [63:0] addr0, wdata0;
  logic [7:0]  strb0;

  int  n_vec = 0;
  int  n_err = 0;
  int  wr_cnt = 0;
  bit  rand_gnt = 1'b0;
  bit  stall = 1'b0;
  logic [63:0] hold_addr, hold_data;
  wr_t exp_q[$];
  wr_t exp_q0[$];

  sig_dump_emitter dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .trap_i(trap), .trap_cause_i(trap_cause),
    .int_raddr_o(int_raddr), .int_rdata_i(int_rdata), .fp_raddr_o(fp_raddr), .fp_rdata_i(fp_rdata),
    .mem_req_o(req), .mem_gnt_i(gnt), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_strb_o(strb), .mem_we_o(we), .busy_o(busy), .done_o(done)
  );

  sig_dump_emitter #(.NR_FP_REGS(0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .start_i(start0), .trap_i(1'b0), .trap_cause_i(64'h0),
    .int_raddr_o(int_raddr0), .int_rdata_i(int_rdata0), .fp_raddr_o(fp_raddr0), .fp_rdata_i(fp_rdata0),
    .mem_req_o(req0), .mem_gnt_i(1'b1), .mem_addr_o(addr0), .mem_wdata_o(wdata0),
    .mem_strb_o(strb0), .mem_we_o(we0), .busy_o(busy0), .done_o(done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register files with one-cycle read latency.
  always @(posedge clk) begin
    int_rdata  <= 64'h1000 + 64'(int_raddr);
    fp_rdata   <= 64'h2000 + 64'(fp_raddr);
    int_rdata0 <= 64'h1000 + 64'(int_raddr0);
    fp_rdata0  <= 64'h2000 + 64'(fp_raddr0);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Grant is chosen at negedge; a req&gnt seen here completes at the following posedge.
  always @(negedge clk) begin
    wr_t e;
    gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst) begin
      if (stall) begin
        check_val("req_held", 64'(req), 64'd1);
        check_val("addr_held", addr, hold_addr);
        check_val("wdata_held", wdata, hold_data);
      end
      if (req) begin
        check_val("we", 64'(we), 64'd1);
        check_val("strb", 64'(strb), 64'hFF);
      end
      if (req && gnt) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_write_addr", addr, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          $display("write #%0d addr=%h data=%h", wr_cnt, addr, wdata);
          check_val("wr_addr", addr, e.a);
          check_val("wr_data", wdata, e.d);
        end
        wr_cnt++;
      end
      stall     = req && !gnt;
      hold_addr = addr;
      hold_data = wdata;
    end else begin
      stall = 1'b0;
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (!rst0 && req0) begin
      check_val("nofp_fp_raddr", 64'(fp_raddr0), 64'd0);
      if (exp_q0.size() == 0) begin
        check_val("nofp_unexpected_addr", addr0, 64'hDEAD);
      end else begin
        e = exp_q0.pop_front();
        $display("nofp write addr=%h data=%h", addr0, wdata0);
        check_val("nofp_wr_addr", addr0, e.a);
        check_val("nofp_wr_data", wdata0, e.d);
      end
    end
  end

  task automatic push_dump(input bit to_q0, input int nfp, input bit with_stop);
    wr_t e;
    for (int i = 1; i <= 31; i++) begin
      e.a = 64'h10; e.d = 64'h1000 + 64'(i);
      if (to_q0) exp_q0.push_back(e); else exp_q.push_back(e);
    end
    for (int i = 0; i < nfp; i++) begin
      e.a = 64'h18; e.d = 64'h2000 + 64'(i);
      if (to_q0) exp_q0.push_back(e); else exp_q.push_back(e);
    end
    if (with_stop) begin
      e.a = 64'h0; e.d = 64'h0;
      if (to_q0) exp_q0.push_back(e); else exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"}, 64'(req), 64'd0);
    check_val({tag, "_we"}, 64'(we), 64'd0);
    check_val({tag, "_strb"}, 64'(strb), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_int_raddr"}, 64'(int_raddr), 64'd0);
    check_val({tag, "_fp_raddr"}, 64'(fp_raddr), 64'd0);
    check_val({tag, "_addr"}, addr, 64'd0);
    check_val({tag, "_wdata"}, wdata, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  // Caller has just set start/trap at posedge+1; the first edge waited on samples them.
  task automatic wait_done(input int bound, input int inject_at, output int lat);
    lat = -1;
    for (int n = 1; n <= bound; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin start = 1'b0; trap = 1'b0; end
      if (n == inject_at) begin start = 1'b1; trap = 1'b1; end
      if (n == inject_at + 1) begin start = 1'b0; trap = 1'b0; end
      if (done) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) check_val("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int lat;
    int base;
    rst = 1'b1; rst0 = 1'b1; start = 1'b0; start0 = 1'b0; trap = 1'b0; trap_cause = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_reset_outputs("reset");
    rst = 1'b0;

    // Full dump with grant always high.
    base = wr_cnt;
    push_dump(1'b0, 32, 1'b1);
    start = 1'b1;
    wait_done(400, 0, lat);
    check_val("done_latency", 64'(lat), 64'd191);
    check_val("q_empty_full", 64'(exp_q.size()), 64'd0);
    check_val("write_count", 64'(wr_cnt - base), 64'd64);
    check_val("busy_after_done", 64'(busy), 64'd0);

    // DONE is terminal: start ignored, done sticky.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_val("done_sticky", 64'(done), 64'd1);
    check_val("done_no_req", 64'(req), 64'd0);

    // Random grant with a start+trap injected mid-dump.
    do_reset();
    rand_gnt = 1'b1;
    base = wr_cnt;
    push_dump(1'b0, 32, 1'b1);
    start = 1'b1;
    wait_done(3000, 60, lat);
    check_val("q_empty_rand", 64'(exp_q.size()), 64'd0);
    check_val("write_count_rand", 64'(wr_cnt - base), 64'd64);
    rand_gnt = 1'b0;

    // Simultaneous trap and start: trap only.
    do_reset();
    base = wr_cnt;
    trap_cause = 64'h2;
    exp_q.push_back('{a: 64'h8, d: 64'h2});
    trap = 1'b1;
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin trap = 1'b0; start = 1'b0; trap_cause = 64'h55; end
      if (n > 1 && !busy) break;
    end
    check_val("trap_busy_clear", 64'(busy), 64'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_val("trap_no_dump_req", 64'(req), 64'd0);
    check_val("trap_write_count", 64'(wr_cnt - base), 64'd1);
    check_val("trap_done_low", 64'(done), 64'd0);
    push_dump(1'b0, 32, 1'b1);
    start = 1'b1;
    wait_done(400, 0, lat);
    check_val("done_latency_after_trap", 64'(lat), 64'd191);
    check_val("q_empty_after_trap", 64'(exp_q.size()), 64'd0);

    // Reset during the FP phase after f5, then restart from x1.
    do_reset();
    base = wr_cnt;
    push_dump(1'b0, 6, 1'b0);
    start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (wr_cnt - base == 37) break;
    end
    check_val("midrst_writes", 64'(wr_cnt - base), 64'd37);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    check_val("q_empty_midrst", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_dump(1'b0, 32, 1'b1);
    start = 1'b1;
    wait_done(400, 0, lat);
    check_val("done_latency_restart", 64'(lat), 64'd191);
    check_val("q_empty_restart", 64'(exp_q.size()), 64'd0);

    // Build without FP phase.
    rst0 = 1'b0;
    push_dump(1'b1, 0, 1'b1);
    start0 = 1'b1;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (n == 1) start0 = 1'b0;
      if (done0) begin
        lat = n - 1;
        break;
      end
    end
    check_val("nofp_done_latency", 64'(lat), 64'd95);
    check_val("nofp_q_empty", 64'(exp_q0.size()), 64'd0);
    check_val("nofp_fp_raddr_end", 64'(fp_raddr0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
